// File: rtl/regfile_arb_pkg.sv
// Shared widths and FSM encoding for the register-file writeback arbiter.
package regfile_arb_pkg;

    localparam int REG_IDX_W      = 5;
    localparam int DATA_W         = 32;
    localparam int NUM_REGS       = 32;
    localparam int PERF_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, scanning upward modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [PTR_W-1:0] idx;

    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = PTR_W'((int'(ptr) + off) % N_REQ);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port among N_REQ writeback sources; halt drain sequencing.
// Latency: 1 cycle from accepted request to RegWrite; index-0 writes are accepted and dropped.
// Backpressure: one-hot req_ready in RUN only; REGARB_PERF_EN adds saturating per-requester wait counters.
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int PTR_W  = $clog2(N_REQ),
    parameter int PERF_W = PERF_W_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*REG_IDX_W-1:0] req_reg,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      RegWrite,
    output logic [REG_IDX_W-1:0]      WriteReg,
    output logic [DATA_W-1:0]         WriteData,
    output logic [NUM_REGS-1:0]       pending_mask,
    input  logic                      halt_req,
    output logic                      halted
`ifdef REGARB_PERF_EN
    ,
    output logic [N_REQ*PERF_W-1:0]   perf_wait
`endif
);

    arb_state_t       state, state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [N_REQ-1:0] gnt;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             arb_en;
    logic             xfer;
    logic [REG_IDX_W-1:0] sel_reg;
    logic [DATA_W-1:0]    sel_dat;

    rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // reset gates ready directly so no accept is visible while reset is held.
    assign arb_en    = reset && (state == RUN) && !halt_req;
    assign req_ready = arb_en ? gnt : '0;
    assign xfer      = arb_en && gnt_vld;

    always_comb begin
        sel_reg = '0;
        sel_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_reg = req_reg[i*REG_IDX_W +: REG_IDX_W];
                sel_dat = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            rr_ptr    <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            state    <= state_nxt;
            RegWrite <= xfer && (sel_reg != '0);
            if (xfer) begin
                rr_ptr <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (xfer && (sel_reg != '0)) begin
                WriteReg  <= sel_reg;
                WriteData <= sel_dat;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (halt_req) state_nxt = DRAIN;
            DRAIN:   if (!RegWrite) state_nxt = HALTED;
            HALTED:  if (!halt_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // The stage always empties one cycle after the last grant, so halted can rise in DRAIN.
    assign halted       = (state == HALTED) || ((state == DRAIN) && !RegWrite);
    assign pending_mask = RegWrite ? (NUM_REGS'(1) << WriteReg) : '0;

`ifdef REGARB_PERF_EN
    logic [N_REQ-1:0][PERF_W-1:0] wait_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && !req_ready[i] && (wait_cnt[i] != '1)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign perf_wait = wait_cnt;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grant order, write latency, drop of r0, halt drain, async reset, perf counters.
module tb_regfile_wb_arbiter;

    localparam int N = 3;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*5-1:0] req_reg;
    logic [N*32-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           RegWrite;
    logic [4:0]     WriteReg;
    logic [31:0]    WriteData;
    logic [31:0]    pending_mask;
    logic           halt_req;
    logic           halted;
`ifdef REGARB_PERF_EN
    logic [N*16-1:0] perf_wait;
`endif

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(.N_REQ(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_reg      (req_reg),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .RegWrite     (RegWrite),
        .WriteReg     (WriteReg),
        .WriteData    (WriteData),
        .pending_mask (pending_mask),
        .halt_req     (halt_req),
        .halted       (halted)
`ifdef REGARB_PERF_EN
        ,
        .perf_wait    (perf_wait)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        halt_req  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        next_cycle();
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '1;
        req_reg   = '0;
        req_data  = '0;
        halt_req  = 1'b0;
        #2;
        check("rst_ready",   32'(req_ready), 32'h0);
        check("rst_we",      32'(RegWrite),  32'h0);
        check("rst_wreg",    32'(WriteReg),  32'h0);
        check("rst_wdata",   WriteData,      32'h0);
        check("rst_pending", pending_mask,   32'h0);
        check("rst_halted",  32'(halted),    32'h0);
        do_reset();

        // single request, 1-cycle latency
        req_valid       = 3'b001;
        req_reg[4:0]    = 5'd5;
        req_data[31:0]  = 32'hDEADBEEF;
        settle();
        check("t1_ready", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = '0;
        settle();
        check("t1_we",      32'(RegWrite), 32'h1);
        check("t1_wreg",    32'(WriteReg), 32'h5);
        check("t1_wdata",   WriteData,     32'hDEADBEEF);
        check("t1_pending", pending_mask,  32'h20);
        next_cycle();
        settle();
        check("t1_we_off",   32'(RegWrite), 32'h0);
        check("t1_pend_off", pending_mask,  32'h0);

        // three requesters held valid: round-robin, no bubbles
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_reg[i*5 +: 5]   = 5'(i + 1);
            req_data[i*32 +: 32] = 32'hA0 + 32'(i);
        end
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            settle();
            check($sformatf("t2_ready_c%0d", c), 32'(req_ready), 32'(1 << (c % 3)));
            if (c > 0) begin
                check($sformatf("t2_we_c%0d", c),    32'(RegWrite), 32'h1);
                check($sformatf("t2_wreg_c%0d", c),  32'(WriteReg), 32'((c - 1) % 3 + 1));
                check($sformatf("t2_wdata_c%0d", c), WriteData,     32'hA0 + 32'((c - 1) % 3));
            end
            next_cycle();
        end
        req_valid = '0;
        settle();
        check("t2_we_last",    32'(RegWrite), 32'h1);
        check("t2_wreg_last",  32'(WriteReg), 32'h3);
        check("t2_wdata_last", WriteData,     32'hA2);

        // write to r0 is accepted and dropped
        next_cycle();
        req_valid         = 3'b010;
        req_reg[9:5]      = 5'd0;
        req_data[63:32]   = 32'h1234;
        settle();
        check("t3_ready", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = '0;
        settle();
        check("t3_we",      32'(RegWrite), 32'h0);
        check("t3_pending", pending_mask,  32'h0);

        // halt drain and resume
        do_reset();
        req_reg[4:0] = 5'd7;
        req_valid    = 3'b001;
        for (int c = 0; c <= 10; c++) begin
            req_data[31:0] = 32'(c);
            halt_req = (c >= 4) && (c < 8);
            settle();
            check($sformatf("t4_ready_c%0d", c),  32'(req_ready), ((c < 4) || (c >= 9)) ? 32'h1 : 32'h0);
            check($sformatf("t4_halted_c%0d", c), 32'(halted),    ((c >= 5) && (c <= 8)) ? 32'h1 : 32'h0);
            check($sformatf("t4_we_c%0d", c),     32'(RegWrite),
                  (((c >= 1) && (c <= 4)) || (c >= 10)) ? 32'h1 : 32'h0);
            if (((c >= 1) && (c <= 4)) || (c >= 10)) begin
                check($sformatf("t4_wdata_c%0d", c), WriteData, 32'(c - 1));
            end
            next_cycle();
        end

        // async reset while the stage is full; pointer returns to req0
        req_valid       = 3'b011;
        req_reg[9:5]    = 5'd9;
        req_data[63:32] = 32'h55;
        settle();
        check("t5_ready_a", 32'(req_ready), 32'h2);
        next_cycle();
        settle();
        check("t5_ready_b", 32'(req_ready), 32'h1);
        check("t5_we_b",    32'(RegWrite),  32'h1);
        check("t5_wreg_b",  32'(WriteReg),  32'h9);
        next_cycle();
        reset = 1'b0;
        #1;
        check("t5_rst_we",      32'(RegWrite), 32'h0);
        check("t5_rst_ready",   32'(req_ready), 32'h0);
        check("t5_rst_pending", pending_mask,  32'h0);
        check("t5_rst_halted",  32'(halted),   32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t5_first_grant", 32'(req_ready), 32'h1);

`ifdef REGARB_PERF_EN
        do_reset();
        req_valid = 3'b011;
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("t6_ready_c%0d", c), 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
            next_cycle();
        end
        req_valid = '0;
        settle();
        check("t6_wait0", 32'(perf_wait[0 +: 16]),  32'h2);
        check("t6_wait1", 32'(perf_wait[16 +: 16]), 32'h2);
        check("t6_wait2", 32'(perf_wait[32 +: 16]), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
